divu_seq: RTL and testbench

- Multi-cycle unsigned 32-bit divider for the course datapath's ALU complex.
- Acts as the initiator side of the ALU subtract path: it issues one trial subtraction per cycle in restoring-division form and consumes the resulting borrow.
- Triggered by the DIVU function code on the shared Signal bus.
- Returns a 32-bit quotient and a 32-bit remainder, which feed the HI/LO registers: remainder goes to HI, quotient goes to LO.

---
 rtl/divu_seq.sv | 109 ++++++++++
 tb/tb_divu_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/divu_seq.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// 32 steps per operation; remainder feeds HI, quotient feeds LO.
module divu_seq #(
  parameter int         WIDTH = 32,
  parameter logic [5:0] DIVU  = 6'b011011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   rq_q, rq_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 divz_q, divz_d;

  logic                 launch;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   rq_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rq_q    <= '0;
      d_q     <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rq_q    <= rq_d;
      d_q     <= d_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
    end
  end

  always_comb begin
    launch = start && (Signal == DIVU);
    // The bit shifted out of R takes part in the trial subtraction so that
    // divisors above 2^31 still divide correctly; a set carry never borrows.
    diff    = rq_q[2*WIDTH-1:WIDTH-1] - {1'b0, d_q};
    rq_step = diff[WIDTH] ? {rq_q[2*WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};

    state_d = state_q;
    count_d = count_q;
    rq_d    = rq_q;
    d_d     = d_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    divz_d  = divz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (launch) begin
          state_d = RUN;
          d_d     = dataB;
          rq_d    = {{WIDTH{1'b0}}, dataA};
          count_d = '0;
          dz_d    = (dataB == '0);
        end
      end
      RUN: begin
        rq_d    = rq_step;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quo_d   = rq_step[WIDTH-1:0];
          rem_d   = rq_step[2*WIDTH-1:WIDTH];
          divz_d  = dz_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    quotient  = quo_q;
    remainder = rem_q;
    div_zero  = divz_q;
  end

endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq: hand-computed quotient/remainder vectors,
// latency, launch qualification, async reset and back-to-back operation.
module tb_divu_seq;

  localparam logic [5:0] DIVU = 6'b011011;

  logic        clk, rst, start;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] last_q, last_r;
  logic        last_dz;

  divu_seq #(.WIDTH(32), .DIVU(DIVU)) dut (
    .clk(clk), .rst(rst), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a qualified start for the edge E0 and check the RUN entry.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; Signal = DIVU; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 1'b0; Signal = 6'd0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_after_start", {31'd0, done}, 32'd0);
  endtask

  // Step E1..E32; optional mid-run start with other operands at E5.
  task automatic finish(input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic inj);
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk); #1;
      if (inj && i == 5) begin
        start = 1'b1; Signal = DIVU; dataA = 32'd9; dataB = 32'd3;
      end
      if (inj && i == 6) begin
        start = 1'b0; Signal = 6'd0;
      end
      if (i == 16) begin
        chk("held_quotient", quotient, last_q);
        chk("held_remainder", remainder, last_r);
        chk("held_div_zero", {31'd0, div_zero}, {31'd0, last_dz});
      end
      if (i == 31) begin
        chk("busy_e31", {31'd0, busy}, 32'd1);
        chk("done_e31", {31'd0, done}, 32'd0);
      end
    end
    @(posedge clk); #1;
    chk("done_e32", {31'd0, done}, 32'd1);
    chk("busy_e32", {31'd0, busy}, 32'd0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_zero", {31'd0, div_zero}, {31'd0, edz});
    last_q = eq; last_r = er; last_dz = edz;
  endtask

  task automatic idle_after;
    @(posedge clk); #1;
    chk("done_e33", {31'd0, done}, 32'd0);
    chk("busy_e33", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; Signal = 6'd0; dataA = '0; dataB = '0;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;

    launch(32'd100, 32'd7);
    finish(32'd14, 32'd2, 1'b0, 1'b0);
    idle_after();

    launch(32'hFFFF_FFFF, 32'd1);
    finish(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    idle_after();

    launch(32'd5, 32'd9);
    finish(32'd0, 32'd5, 1'b0, 1'b0);
    idle_after();

    launch(32'hFFFF_FFFF, 32'h8000_0001);
    finish(32'd1, 32'h7FFF_FFFE, 1'b0, 1'b0);
    idle_after();

    launch(32'd1234, 32'd0);
    finish(32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
    idle_after();

    // Unqualified start: nothing moves for a full operation's worth of cycles.
    @(negedge clk);
    start = 1'b1; Signal = 6'b100000; dataA = 32'd50; dataB = 32'd5;
    @(negedge clk);
    start = 1'b0; Signal = 6'd0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("badsig_busy", {31'd0, busy}, 32'd0);
      chk("badsig_done", {31'd0, done}, 32'd0);
    end
    chk("badsig_quotient", quotient, 32'hFFFF_FFFF);
    chk("badsig_remainder", remainder, 32'd1234);
    chk("badsig_div_zero", {31'd0, div_zero}, 32'd1);

    // Start during RUN is ignored: 200/9 = 22 r 2.
    launch(32'd200, 32'd9);
    finish(32'd22, 32'd2, 1'b0, 1'b1);
    idle_after();

    // Asynchronous reset mid-operation.
    launch(32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_quotient", quotient, 32'd0);
    chk("arst_remainder", remainder, 32'd0);
    chk("arst_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    launch(32'd50, 32'd5);
    finish(32'd10, 32'd0, 1'b0, 1'b0);
    idle_after();

    // Back-to-back: second start sampled in the DONE cycle.
    launch(32'd77, 32'd8);
    finish(32'd9, 32'd5, 1'b0, 1'b0);
    launch(32'd640, 32'd32);
    finish(32'd20, 32'd0, 1'b0, 1'b0);
    idle_after();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
